// File: rtl/wb_pkg.sv
// wb_pkg: writeback source encodings, load funct3 codes and default datapath width
package wb_pkg;
  localparam int DWIDTH = 32;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wbsel_e;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
endpackage

// File: rtl/load_extract.sv
// load_extract: combinational load data extraction (memdata, funct3, off -> sign/zero-extended data, misalign)
module load_extract
  import wb_pkg::*;
(
  input  logic [DWIDTH-1:0] memdata,
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  output logic [DWIDTH-1:0] data,
  output logic              misalign
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = memdata[8*off +: 8];
  assign h = off[1] ? memdata[31:16] : memdata[15:0];
  assign data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                funct3 == F3_LBU ? {24'b0, b} :
                funct3 == F3_LH  ? {{16{h[15]}}, h} :
                funct3 == F3_LHU ? {16'b0, h} :
                funct3 == F3_LW  ? memdata : '0;
  assign misalign = (funct3 == F3_LH || funct3 == F3_LHU) ? off[0] :
                    funct3 == F3_LW ? |off : 1'b0;
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register driving regfile write port (rd_o/datawb_o/regwren_o), valid_o/pc_o/misalign_o, 64-bit instret_o; WB_FORWARD_EN adds rs1/rs2 forwarding ports
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DWIDTH = wb_pkg::DWIDTH,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  input  logic [1:0]        wbsel_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] memdata_i,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic              misalign_o,
  output logic [63:0]       instret_o
`ifdef WB_FORWARD_EN
  ,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic [DWIDTH-1:0] rs1_fwd_o,
  output logic [DWIDTH-1:0] rs2_fwd_o,
  output logic              rs1_hit_o,
  output logic              rs2_hit_o
`endif
);
  logic [DWIDTH-1:0] ld_data, wb_data;
  logic ld_mis, mis;
  load_extract u_ld (.memdata(memdata_i), .funct3(funct3_i), .off(alu_res_i[1:0]), .data(ld_data), .misalign(ld_mis));
  assign mis = valid_i & (wbsel_i == WB_MEM) & ld_mis;
  assign wb_data = wbsel_i == WB_ALU ? alu_res_i :
                   wbsel_i == WB_MEM ? ld_data :
                   wbsel_i == WB_PC4 ? DWIDTH'(pc_i + AWIDTH'(4)) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_o       <= '0;
      datawb_o   <= '0;
      regwren_o  <= 1'b0;
      valid_o    <= 1'b0;
      pc_o       <= '0;
      misalign_o <= 1'b0;
      instret_o  <= '0;
    end else if (flush_i) begin
      rd_o       <= '0;
      datawb_o   <= '0;
      regwren_o  <= 1'b0;
      valid_o    <= 1'b0;
      pc_o       <= '0;
      misalign_o <= 1'b0;
    end else if (!stall_i) begin
      rd_o       <= rd_i;
      datawb_o   <= wb_data;
      regwren_o  <= valid_i & regwren_i & (|rd_i) & ~mis;
      valid_o    <= valid_i;
      pc_o       <= pc_i;
      misalign_o <= mis;
      instret_o  <= instret_o + 64'(valid_i & ~mis);
    end
  end
`ifdef WB_FORWARD_EN
  assign rs1_hit_o = regwren_o & (rd_o == rs1_i);
  assign rs2_hit_o = regwren_o & (rd_o == rs2_i);
  assign rs1_fwd_o = rs1_hit_o ? datawb_o : '0;
  assign rs2_fwd_o = rs2_hit_o ? datawb_o : '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed plus random checks of writeback_stage against a behavioural model
module tb_writeback_stage;
  logic clk = 1'b0;
  logic rst, valid_i, stall_i, flush_i, regwren_i;
  logic [31:0] pc_i, alu_res_i, memdata_i;
  logic [4:0] rd_i;
  logic [1:0] wbsel_i;
  logic [2:0] funct3_i;
  logic [4:0] rd_o;
  logic [31:0] datawb_o, pc_o;
  logic regwren_o, valid_o, misalign_o;
  logic [63:0] instret_o;
`ifdef WB_FORWARD_EN
  logic [4:0] rs1_i, rs2_i;
  logic [31:0] rs1_fwd_o, rs2_fwd_o;
  logic rs1_hit_o, rs2_hit_o;
`endif
  int total = 0, bad = 0;
  bit m_valid, m_wren, m_mis;
  bit [4:0] m_rd;
  bit [31:0] m_data, m_pc;
  bit [63:0] m_ir;
  writeback_stage dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .pc_i(pc_i), .rd_i(rd_i), .regwren_i(regwren_i), .wbsel_i(wbsel_i), .funct3_i(funct3_i),
    .alu_res_i(alu_res_i), .memdata_i(memdata_i), .rd_o(rd_o), .datawb_o(datawb_o),
    .regwren_o(regwren_o), .valid_o(valid_o), .pc_o(pc_o), .misalign_o(misalign_o),
    .instret_o(instret_o)
`ifdef WB_FORWARD_EN
    , .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_fwd_o(rs1_fwd_o), .rs2_fwd_o(rs2_fwd_o),
    .rs1_hit_o(rs1_hit_o), .rs2_hit_o(rs2_hit_o)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic bit [31:0] load_val(bit [31:0] mem, bit [2:0] f3, bit [1:0] off, output bit misal);
    int sz, base;
    bit sg;
    bit [31:0] raw, mask;
    misal = 1'b0;
    case (f3)
      3'd0: begin sz = 1; sg = 1; end
      3'd1: begin sz = 2; sg = 1; end
      3'd2: begin sz = 4; sg = 0; end
      3'd4: begin sz = 1; sg = 0; end
      3'd5: begin sz = 2; sg = 0; end
      default: return 32'd0;
    endcase
    base = int'(off) - int'(off) % sz;
    raw = mem >> (8 * base);
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      raw = raw & mask;
      if (sg && raw[8*sz-1]) raw = raw | ~mask;
    end
    misal = (int'(off) % sz) != 0;
    return raw;
  endfunction
  task automatic model();
    bit lm, mis;
    bit [31:0] ld;
    if (rst) begin
      {m_valid, m_wren, m_mis, m_rd, m_data, m_pc} = '0;
      m_ir = 0;
    end else if (flush_i) begin
      {m_valid, m_wren, m_mis, m_rd, m_data, m_pc} = '0;
    end else if (!stall_i) begin
      ld = load_val(memdata_i, funct3_i, alu_res_i[1:0], lm);
      mis = valid_i && wbsel_i == 2'd1 && lm;
      m_valid = valid_i;
      m_rd = rd_i;
      m_pc = pc_i;
      m_mis = mis;
      m_wren = valid_i && regwren_i && rd_i != 0 && !mis;
      m_data = wbsel_i == 2'd0 ? alu_res_i : wbsel_i == 2'd1 ? ld : wbsel_i == 2'd2 ? pc_i + 32'd4 : 32'd0;
      if (valid_i && !mis) m_ir = m_ir + 1;
    end
  endtask
  task automatic compare_all();
    chk("m_rd", 64'(rd_o), 64'(m_rd));
    chk("m_data", 64'(datawb_o), 64'(m_data));
    chk("m_wren", 64'(regwren_o), 64'(m_wren));
    chk("m_valid", 64'(valid_o), 64'(m_valid));
    chk("m_pc", 64'(pc_o), 64'(m_pc));
    chk("m_mis", 64'(misalign_o), 64'(m_mis));
    chk("m_instret", instret_o, m_ir);
`ifdef WB_FORWARD_EN
    chk("m_hit1", 64'(rs1_hit_o), 64'(m_wren && m_rd == rs1_i));
    chk("m_hit2", 64'(rs2_hit_o), 64'(m_wren && m_rd == rs2_i));
    chk("m_fwd1", 64'(rs1_fwd_o), 64'((m_wren && m_rd == rs1_i) ? m_data : 32'd0));
    chk("m_fwd2", 64'(rs2_fwd_o), 64'((m_wren && m_rd == rs2_i) ? m_data : 32'd0));
`endif
  endtask
  task automatic tick();
    @(posedge clk);
    model();
    #1 compare_all();
  endtask
  initial begin
    {valid_i, stall_i, flush_i, regwren_i, pc_i, alu_res_i, memdata_i, rd_i, wbsel_i, funct3_i} = '0;
`ifdef WB_FORWARD_EN
    rs1_i = 0;
    rs2_i = 0;
`endif
    rst = 1;
    tick();
    tick();
    chk("rst_valid", 64'(valid_o), 0);
    chk("rst_data", 64'(datawb_o), 0);
    chk("rst_instret", instret_o, 0);
    rst = 0;
    valid_i = 1; rd_i = 5; regwren_i = 1; wbsel_i = 0; alu_res_i = 32'hDEADBEEF;
    tick();
    chk("alu_rd", 64'(rd_o), 5);
    chk("alu_data", 64'(datawb_o), 64'h0DEADBEEF);
    chk("alu_wren", 64'(regwren_o), 1);
    chk("alu_instret", instret_o, 1);
    wbsel_i = 1; memdata_i = 32'h80FF7F01; rd_i = 6;
    funct3_i = 0; alu_res_i = 3; tick(); chk("lb", 64'(datawb_o), 64'hFFFFFF80);
    funct3_i = 4; alu_res_i = 1; tick(); chk("lbu", 64'(datawb_o), 64'h7F);
    funct3_i = 1; alu_res_i = 2; tick(); chk("lh", 64'(datawb_o), 64'hFFFF80FF);
    funct3_i = 5; alu_res_i = 0; tick(); chk("lhu", 64'(datawb_o), 64'h7F01);
    funct3_i = 2; alu_res_i = 2; tick();
    chk("lw_mis", 64'(misalign_o), 1);
    chk("lw_mis_wren", 64'(regwren_o), 0);
    chk("lw_mis_instret", instret_o, 5);
    funct3_i = 1; alu_res_i = 1; tick();
    chk("lh_mis", 64'(misalign_o), 1);
    chk("lh_mis_wren", 64'(regwren_o), 0);
    chk("lh_mis_instret", instret_o, 5);
    wbsel_i = 2; pc_i = 32'h01000010; rd_i = 1; tick();
    chk("jal_data", 64'(datawb_o), 64'h01000014);
    chk("jal_wren", 64'(regwren_o), 1);
    rd_i = 0; tick();
    chk("jal_x0_wren", 64'(regwren_o), 0);
    chk("jal_x0_valid", 64'(valid_o), 1);
    wbsel_i = 0; alu_res_i = 32'h1111; rd_i = 3; tick();
    stall_i = 1; alu_res_i = 32'h2222; rd_i = 4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", 64'(datawb_o), 64'h1111);
      chk("stall_rd", 64'(rd_o), 3);
      chk("stall_instret", instret_o, 8);
    end
    flush_i = 1; tick();
    chk("flush_valid", 64'(valid_o), 0);
    chk("flush_wren", 64'(regwren_o), 0);
    flush_i = 0; stall_i = 0;
`ifdef WB_FORWARD_EN
    rd_i = 7; alu_res_i = 32'h1234; rs1_i = 7; rs2_i = 0; tick();
    chk("fwd_hit1", 64'(rs1_hit_o), 1);
    chk("fwd_data1", 64'(rs1_fwd_o), 64'h1234);
    chk("fwd_hit2", 64'(rs2_hit_o), 0);
`endif
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom % 60) == 0;
      stall_i = ($urandom % 6) == 0;
      flush_i = ($urandom % 9) == 0;
      valid_i = ($urandom % 4) != 0;
      regwren_i = ($urandom % 5) != 0;
      rd_i = 5'($urandom % 8);
      wbsel_i = 2'($urandom);
      funct3_i = 3'($urandom);
      pc_i = ($urandom % 3) == 0 ? 32'hFFFFFFFC : $urandom;
      alu_res_i = $urandom;
      memdata_i = $urandom;
`ifdef WB_FORWARD_EN
      rs1_i = 5'($urandom % 8);
      rs2_i = 5'($urandom % 8);
`endif
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline stage directly upstream of the register file.
- Captures memory-stage results into a pipeline register.
- Extracts and sign/zero-extends load data, then selects the writeback source.
- Drives the register file's write port (rd, data, write enable) and keeps a retired-instruction counter.

Parameters:
- DWIDTH, 32, datapath width; only 32 is supported.
- AWIDTH, 32, PC width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  memory-stage instruction valid
- stall_i  in  1  hold pipeline register contents
- flush_i  in  1  squash the incoming instruction (insert bubble)
- pc_i  in  AWIDTH  instruction PC
- rd_i  in  5  destination register
- regwren_i  in  1  instruction writes rd
- wbsel_i  in  2  writeback source: 0 ALU, 1 MEM, 2 PC+4, 3 reserved
- funct3_i  in  3  load width/sign (LB=0, LH=1, LW=2, LBU=4, LHU=5)
- alu_res_i  in  DWIDTH  ALU result; bits [1:0] are the load byte offset
- memdata_i  in  DWIDTH  raw aligned data-memory word
- rd_o  out  5  register-file write address
- datawb_o  out  DWIDTH  register-file write data
- regwren_o  out  1  register-file write enable
- valid_o  out  1  stage holds a valid instruction
- pc_o  out  AWIDTH  PC of the instruction in the stage
- misalign_o  out  1  registered load-misalignment flag
- instret_o  out  64  retired-instruction count

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Reset: all outputs and internal registers are 0, including instret_o.
- Latency: inputs are sampled at posedge; outputs appear the following cycle, all registered.
- Priority: rst > flush_i > stall_i > normal capture.
- flush_i: valid_o <= 0, regwren_o <= 0, misalign_o <= 0; other fields don't-care (implement as 0).
- stall_i (no flush): every register holds its value; instret_o does not increment.
- Normal: capture; valid_o <= valid_i.
- regwren_o <= valid_i & regwren_i & (rd_i != 0) & ~misalign.
- Load extract, combinational before the register, with off = alu_res_i[1:0]:
  - LB/LBU: byte at off, sign- or zero-extended.
  - LH/LHU: halfword at off[1]; misaligned if off[0]=1.
  - LW: full word; misaligned if off != 0.
  - Other funct3 values: result 0, not misaligned.
- Misalignment: misalign is asserted only when wbsel_i = MEM and valid_i. It suppresses the write and is registered to misalign_o.
- Writeback data: datawb_o <= ALU result, extracted load data, or pc_i+4 (modulo 2^32) per wbsel_i. The reserved encoding gives 0.
- instret: increments by 1 on each non-stalled, non-flushed capture with valid_i=1 and no misalignment. Wraps 2^64-1 -> 0.
- The register file has no write-through; a same-cycle read of rd_o returns the old value unless forwarding is enabled.

Optional Feature:
- Macro: WB_FORWARD_EN.
- When defined, adds four ports:
  - rs1_i in 5, rs2_i in 5.
  - rs1_fwd_o out DWIDTH, rs2_fwd_o out DWIDTH.
  - rs1_hit_o out 1, rs2_hit_o out 1.
- Forwarding is combinational: rsX_hit_o = regwren_o & (rd_o == rsX_i), and rsX_fwd_o = datawb_o when hit, else 0.
- When not defined, these ports and the forwarding logic are absent; behaviour is otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - wbsel_e enum: WB_ALU, WB_MEM, WB_PC4.
  - Load funct3 localparams: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - DWIDTH default.
- Sub-module load_extract: purely combinational; inputs memdata, funct3, off; outputs data and misalign. The stage instantiates it once.

Test Plan:
- Reset and ALU writeback: assert rst 2 cycles -> all outputs 0. Then ALU writeback of alu_res_i=0xDEADBEEF with rd_i=5, regwren_i=1, valid_i=1 -> next cycle rd_o=5, datawb_o=0xDEADBEEF, regwren_o=1, instret_o=1.
- Loads: memdata_i=0x80FF7F01.
  - LB off=3 -> datawb_o=0xFFFFFF80.
  - LBU off=1 -> 0x0000007F.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
- Misaligned load: LW with off=2 -> misalign_o=1, regwren_o=0, instret_o unchanged. LH with off=1 -> same result.
- JAL link: wbsel=PC4, pc_i=0x01000010 -> datawb_o=0x01000014. With rd_i=0 -> regwren_o=0 while valid_o=1.
- Stall and flush: stall_i held 3 cycles -> outputs frozen and instret_o constant. flush_i together with stall_i -> valid_o=0, regwren_o=0.
- Forwarding (WB_FORWARD_EN defined): rd_o=7 writing 0x1234, rs1_i=7, rs2_i=0 -> rs1_hit_o=1, rs1_fwd_o=0x1234, rs2_hit_o=0.
